// File: rtl/input_debounce_if.sv
// Signal bundle between the raw button side and the debounced consumer side.
// The master drives the raw input and the glitch clear; the slave returns the debounced result.
interface input_debounce_if #(
  parameter int CNT_W = 8
);
  logic             btn;
  logic             clr_glitch;
  logic             a;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] glitches;

  modport master (
    output btn, clr_glitch,
    input  a, rise, fall, glitches
  );

  modport slave (
    input  btn, clr_glitch,
    output a, rise, fall, glitches
  );
endinterface

// File: rtl/input_debounce.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state FSM that accepts a level
// only after DEBOUNCE_CYCLES consecutive equal samples, with edge pulses and a glitch counter.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input logic             clk,
  input logic             reset,
  input_debounce_if.slave bus
);

  typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} state_t;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             btn_s;
  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             a_q, a_nxt;
  logic             rise_q, rise_nxt;
  logic             fall_q, fall_nxt;
  logic             glitch_evt;
  logic [CNT_W-1:0] glitches_q, glitches_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0/p1: synchronizer, the only place btn is sampled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_p0 <= bus.btn;
      btn_s   <= sync_p0;
    end
  end

  // Stage p2: FSM decision on btn_s and the current state only
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    glitch_evt = 1'b0;
    case (state)
      LO: begin
        if (btn_s) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = 8'd1;
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_nxt  = LO;
          cnt_nxt    = 8'd0;
          glitch_evt = 1'b1;
        end else if (cnt == LAST) begin
          state_nxt = HI;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HI: begin
        if (!btn_s) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = 8'd1;
        end
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_nxt  = HI;
          cnt_nxt    = 8'd0;
          glitch_evt = 1'b1;
        end else if (cnt == LAST) begin
          state_nxt = LO;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = LO;
        cnt_nxt   = 8'd0;
      end
    endcase

    a_nxt    = (state_nxt == HI) || (state_nxt == WAIT_LO);
    rise_nxt = (state == WAIT_HI) && (state_nxt == HI);
    fall_nxt = (state == WAIT_LO) && (state_nxt == LO);

    // Clear takes priority over a same-cycle glitch
    if (bus.clr_glitch)
      glitches_nxt = '0;
    else if (glitch_evt)
      glitches_nxt = sat_inc(glitches_q);
    else
      glitches_nxt = glitches_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LO;
      cnt        <= 8'd0;
      a_q        <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      glitches_q <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      a_q        <= a_nxt;
      rise_q     <= rise_nxt;
      fall_q     <= fall_nxt;
      glitches_q <= glitches_nxt;
    end
  end

  assign bus.a        = a_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.glitches = glitches_q;

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive synchronized samples required to accept a level change; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: width of the glitch counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn  input  1  raw, asynchronous, bouncy external input.
REQ-006 clr_glitch  input  1  synchronous clear of the glitch counter.
REQ-007 a  output  1  debounced level; drives the downstream FSM input a.
REQ-008 rise  output  1  single-cycle pulse on the first cycle a is 1.
REQ-009 fall  output  1  single-cycle pulse on the first cycle a is 0.
REQ-010 glitches  output  CNT_W  saturating count of aborted transitions.

Function
REQ-011 btn SHALL pass through a two-flop synchronizer; btn_s is the second-stage output; no other logic SHALL sample btn.
REQ-012 Control SHALL be a four-state FSM: LO, WAIT_HI, HI, WAIT_LO, with a stability counter cnt of at least 8 bits.
REQ-013 LO: a=0; btn_s=1 -> WAIT_HI with cnt=1; else stay.
REQ-014 WAIT_HI: a=0; btn_s=0 -> LO, glitches increments; btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HI; btn_s=1 otherwise -> cnt+1.
REQ-015 HI: a=1; btn_s=0 -> WAIT_LO with cnt=1; else stay.
REQ-016 WAIT_LO: a=1; btn_s=1 -> HI, glitches increments; btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> LO; btn_s=0 otherwise -> cnt+1.
REQ-017 a SHALL be a registered Moore output: 1 exactly in HI and WAIT_LO.
REQ-018 Latency: btn first sampled high at edge N and held stable -> a=1 after edge N+DEBOUNCE_CYCLES+1; falling is symmetric.
REQ-019 rise SHALL be registered and high for exactly the one cycle following the WAIT_HI->HI edge; fall likewise for WAIT_LO->LO; rise and fall SHALL never be high together.
REQ-020 A pulse on btn shorter than DEBOUNCE_CYCLES synchronized samples SHALL NOT change a, rise or fall.
REQ-021 glitches SHALL saturate at all-ones and SHALL NOT wrap.
REQ-022 clr_glitch=1 SHALL set glitches to 0 on the next edge; clear wins over a simultaneous increment.
REQ-023 The HI/LO decision SHALL depend only on btn_s and the current state; there SHALL be no hysteresis beyond the FSM.

Reset
REQ-024 reset=1 SHALL immediately clear both synchronizer flops, set state to LO, and set cnt=0, a=0, rise=0, fall=0 and glitches=0, independent of clk.
REQ-025 Reset asserted mid-debounce SHALL abandon the pending transition without pulsing rise or fall or counting a glitch.
REQ-026 If btn is high when reset deasserts, the block SHALL perform a full debounce from LO and emit one rise pulse.

Verification
REQ-027 DEBOUNCE_CYCLES=4; btn rises and is first sampled at edge 10, then held -> a=1 and rise=1 after edge 15; rise=0 after edge 16; glitches=0.
REQ-028 a=0; btn high for 2 cycles, then low -> a stays 0, rise never asserts, glitches=1.
REQ-029 a=1; btn bounces 1-0-1-0-1-0 at 1-cycle spacing, then holds low -> a falls once, exactly one fall pulse, and glitches grows by the number of aborted WAIT_LO entries.
REQ-030 CNT_W=2; drive 5 short glitches -> glitches reads 3 after the 3rd and after the 5th glitch; clr_glitch coincident with a glitch -> glitches=0.
REQ-031 Assert reset asynchronously (between clock edges) while in WAIT_HI with cnt=2 -> all outputs read 0 before the next edge; after release with btn held high -> a=1 DEBOUNCE_CYCLES+1 edges after the first high sample, with one rise pulse.
REQ-032 Connect to the downstream FSM and run a random bouncy btn; a scoreboard checks that a changes only after DEBOUNCE_CYCLES stable samples and that rise/fall pulses match the edges of a one-for-one.
